// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register family.
package pipe_pkg;

  localparam int PIPE_DEF_WIDTH = 32;
  localparam int PIPE_DEF_DEPTH = 2;

  // Occupancy counter width: enough bits to hold every value 0..depth inclusive.
  function automatic int pipe_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_ptr_ctrl.sv
// Pointer and occupancy bookkeeping for elastic_pipe_reg; produces the handshake
// qualifiers so the storage wrapper only has to write and read the array.
module elastic_ptr_ctrl
  import pipe_pkg::*;
#(
  parameter  int DEPTH = PIPE_DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = pipe_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          push,
  output logic          pop,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Handshake qualifiers depend only on registered occupancy, never on the far side's ready.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != {CW{1'b0}});
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Next-state pointers and count; flush squashes everything including same-cycle traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-entry first-word-fall-through pipeline register with valid/ready on both
// sides and a synchronous flush; stored words are always registered before they are shown.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter  int WIDTH = PIPE_DEF_WIDTH,
  parameter  int DEPTH = PIPE_DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = pipe_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [WIDTH-1:0] mem_q [DEPTH];

  elastic_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .push      (push),
    .pop       (pop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  // Storage is left unreset; its contents are never visible while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  // Head word, masked to zero whenever nothing is stored.
  always_comb begin
    if (out_valid) begin
      out_data = mem_q[rd_ptr];
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and scoreboard-checked bench for elastic_pipe_reg at DEPTH=2/WIDTH=32 and DEPTH=4/WIDTH=8.
module tb_elastic_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default geometry
  logic        a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_data = 32'h0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;

  // Instance B: wrap and random geometry
  logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0]  b_in_data = 8'h0;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [2:0]  b_count;

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count)
  );

  elastic_pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  int         cnt;
  logic       iv, ord, fl;
  logic [7:0] dat;

  initial begin
    // Reset with an offered word that must not be taken
    a_rst = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF;
    b_rst = 1'b0;
    step();
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    a_rst = 1'b1; b_rst = 1'b1;

    // Fill and drain
    a_in_valid = 1'b1; a_in_data = 32'h11; a_out_ready = 1'b0;
    step();
    chk("fill1_count", 32'(a_count), 32'd1);
    chk("fill1_valid", 32'(a_out_valid), 32'd1);
    chk("fill1_data", a_out_data, 32'h11);
    a_in_data = 32'h22;
    step();
    chk("fill2_count", 32'(a_count), 32'd2);
    chk("fill2_in_ready", 32'(a_in_ready), 32'd0);
    a_in_data = 32'h33;
    step();
    chk("full_hold_count", 32'(a_count), 32'd2);
    chk("full_hold_data", a_out_data, 32'h11);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("drain1_data", a_out_data, 32'h11);
    step();
    chk("drain2_data", a_out_data, 32'h22);
    chk("drain2_in_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("drain_empty_valid", 32'(a_out_valid), 32'd0);
    chk("drain_empty_data", a_out_data, 32'd0);
    chk("drain_empty_count", 32'(a_count), 32'd0);

    // Streaming: one cycle lag, occupancy pinned at one
    a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = 32'd0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("stream_count", 32'(a_count), 32'd1);
      chk("stream_data", a_out_data, 32'(i));
      a_in_data = 32'(i + 1);
    end
    a_in_valid = 1'b0;
    step();
    chk("stream_end_count", 32'(a_count), 32'd0);

    // Flush with simultaneous push and pop offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    step();
    a_in_data = 32'hB;
    step();
    chk("flush_pre_count", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_in_data = 32'hC; a_out_ready = 1'b1;
    step();
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_data", a_out_data, 32'd0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd1);
    a_flush = 1'b0; a_in_data = 32'hD; a_out_ready = 1'b0;
    step();
    chk("post_flush_data", a_out_data, 32'hD);
    chk("post_flush_count", 32'(a_count), 32'd1);
    a_in_valid = 1'b0;

    // Random traffic on DEPTH=4 against a queue model
    for (int c = 0; c < 10000; c++) begin
      cnt = q.size();
      chk("rnd_count", 32'(b_count), 32'(cnt));
      chk("rnd_in_ready", 32'(b_in_ready), 32'(cnt != 4));
      chk("rnd_out_valid", 32'(b_out_valid), 32'(cnt != 0));
      chk("rnd_out_data", 32'(b_out_data), (cnt != 0) ? 32'(q[0]) : 32'd0);
      iv  = 1'($urandom_range(1, 0));
      ord = 1'($urandom_range(1, 0));
      fl  = ($urandom_range(99, 0) < 5);
      dat = 8'($urandom);
      b_in_valid = iv; b_out_ready = ord; b_flush = fl; b_in_data = dat;
      if (fl) begin
        q.delete();
      end else begin
        if (ord && cnt != 0) void'(q.pop_front());
        if (iv && cnt != 4) q.push_back(dat);
      end
      step();
    end

    // Reset in the middle of traffic at count=3
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b1;
    step();
    b_flush = 1'b0; b_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_data = 8'(8'h51 + k);
      step();
    end
    chk("mid_pre_count", 32'(b_count), 32'd3);
    b_in_data = 8'h54; b_out_ready = 1'b1; b_rst = 1'b0;
    step();
    chk("mid_rst_count", 32'(b_count), 32'd0);
    chk("mid_rst_valid", 32'(b_out_valid), 32'd0);
    chk("mid_rst_data", 32'(b_out_data), 32'd0);
    b_rst = 1'b1; b_in_data = 8'h60; b_out_ready = 1'b0;
    step();
    chk("mid_post_data", 32'(b_out_data), 32'h60);
    chk("mid_post_count", 32'(b_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
